// File: rtl/cs_seq_if.sv
// Command channel into the chip-select sequencer:
// one target/length command per valid/ready handshake.
interface cs_seq_if #(
    parameter int LEN_W = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [3:0]       s_target;
    logic [LEN_W-1:0] s_len;

    modport master (
        output s_valid,
        output s_target,
        output s_len,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_target,
        input  s_len,
        output s_ready
    );
endinterface

// File: rtl/cs_seq.sv
// Chip-select sequencer: one bounded cfg window per command,
// followed by a forced deselect gap before the next accept.
module cs_seq #(
    parameter int LEN_W      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic       aclk,
    input  logic       areset,
    cs_seq_if.slave    s,
    input  logic       abort,
    output logic [4:0] cfg,
    output logic       cs_active,
    output logic       done,
    output logic       done_abort
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } state_t;

    localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       gap_q, gap_d;
    logic [4:0]       cfg_q, cfg_d;
    logic             done_q, done_d;
    logic             dab_q, dab_d;

    logic             accept;
    logic [LEN_W-1:0] len_eff;

    assign s.s_ready = (state_q == IDLE) && !areset;
    assign accept    = s.s_valid && s.s_ready;
    assign len_eff   = (s.s_len == '0) ? LEN_W'(1) : s.s_len;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        cfg_d   = cfg_q;
        done_d  = 1'b0;
        dab_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ASSERT;
                    cnt_d   = len_eff - LEN_W'(1);
                    cfg_d   = {1'b1, s.s_target};
                end
            end
            ASSERT: begin
                // abort wins over the natural last count
                if (abort || cnt_q == '0) begin
                    state_d  = GAP;
                    gap_d    = GapLast;
                    cfg_d[4] = 1'b0;
                    done_d   = 1'b1;
                    dab_d    = abort;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cfg_d   = '0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            cfg_q   <= '0;
            done_q  <= 1'b0;
            dab_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            cfg_q   <= cfg_d;
            done_q  <= done_d;
            dab_q   <= dab_d;
        end
    end

    assign cfg        = cfg_q;
    assign cs_active  = cfg_q[4];
    assign done       = done_q;
    assign done_abort = dab_q;

endmodule

// File: tb/tb_cs_seq.sv
// Directed bench for cs_seq: expected per-cycle outputs are queued
// when a command is driven and popped one per clock.
module tb_cs_seq;

    localparam int LEN_W = 8;
    localparam int GAP   = 2;

    logic       aclk = 1'b0;
    logic       areset;
    logic       abort;
    logic [4:0] cfg;
    logic       cs_active;
    logic       done;
    logic       done_abort;

    cs_seq_if #(.LEN_W(LEN_W)) bus ();

    cs_seq #(
        .LEN_W(LEN_W),
        .GAP_CYCLES(GAP)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s(bus.slave),
        .abort(abort),
        .cfg(cfg),
        .cs_active(cs_active),
        .done(done),
        .done_abort(done_abort)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [4:0] c;
        logic       d;
        logic       da;
        logic       r;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(input string tag, input logic [4:0] obs,
                       input logic [4:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b",
                   tag, cyc, obs, expv);
        end
    endtask

    task automatic push(input logic [4:0] c, input logic d,
                        input logic da, input logic r);
        exp_t e;
        e.c  = c;
        e.d  = d;
        e.da = da;
        e.r  = r;
        q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge aclk);
        #1;
        cyc++;
        checks++;
        assert (q.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty cycle=%0d observed=0 expected>0",
                   cyc);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("cfg", cfg, e.c);
            chk("cs_active", {4'b0, cs_active}, {4'b0, e.c[4]});
            chk("done", {4'b0, done}, {4'b0, e.d});
            chk("done_abort", {4'b0, done_abort}, {4'b0, e.da});
            chk("s_ready", {4'b0, bus.s_ready}, {4'b0, e.r});
        end
    endtask

    // ab_at: assert-cycle index carrying abort (0 = none)
    // noise: keep abort high through GAP and the following IDLE
    // keep : leave s_valid high and present nt as the next target
    task automatic run_cmd(input logic [3:0] t, input int len,
                           input int ab_at, input bit noise,
                           input bit keep, input logic [3:0] nt);
        int   eff;
        int   n;
        int   total;
        logic dab;
        eff   = (len == 0) ? 1 : len;
        n     = (ab_at > 0 && ab_at < eff) ? ab_at : eff;
        dab   = (ab_at > 0 && ab_at <= eff);
        total = n + GAP + 1;
        for (int i = 0; i < n; i++) push({1'b1, t}, 1'b0, 1'b0, 1'b0);
        push({1'b0, t}, 1'b1, dab, 1'b0);
        for (int i = 1; i < GAP; i++) push({1'b0, t}, 1'b0, 1'b0, 1'b0);
        push({1'b0, t}, 1'b0, 1'b0, 1'b1);
        bus.s_target = t;
        bus.s_len    = LEN_W'(len);
        bus.s_valid  = 1'b1;
        for (int i = 1; i <= total; i++) begin
            tick();
            if (i == 1) begin
                if (keep) begin
                    bus.s_target = nt;
                end else begin
                    bus.s_valid  = 1'b0;
                    bus.s_target = ~t;
                    bus.s_len    = 8'hFF;
                end
            end
            abort = (i == ab_at) || (noise && i > n);
        end
        if (noise) begin
            push({1'b0, t}, 1'b0, 1'b0, 1'b1);
            tick();
        end
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d observed=running expected=finished",
                 cyc);
        $fatal(1);
    end

    initial begin
        areset       = 1'b1;
        abort        = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_target = 4'h0;
        bus.s_len    = '0;

        for (int i = 0; i < 3; i++) begin
            push(5'b00000, 1'b0, 1'b0, 1'b0);
            tick();
        end
        areset = 1'b0;
        push(5'b00000, 1'b0, 1'b0, 1'b1);
        tick();

        run_cmd(4'h5, 3, 0, 1'b0, 1'b0, 4'h0);
        run_cmd(4'hA, 0, 0, 1'b0, 1'b0, 4'h0);

        run_cmd(4'h2, 4, 0, 1'b0, 1'b1, 4'h9);
        run_cmd(4'h9, 4, 0, 1'b0, 1'b0, 4'h0);

        run_cmd(4'h7, 10, 4, 1'b1, 1'b0, 4'h0);

        // reset on the 2nd cycle of a 5-cycle window
        push(5'b10011, 1'b0, 1'b0, 1'b0);
        bus.s_target = 4'h3;
        bus.s_len    = 8'd5;
        bus.s_valid  = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        push(5'b10011, 1'b0, 1'b0, 1'b0);
        tick();
        areset = 1'b1;
        push(5'b00000, 1'b0, 1'b0, 1'b0);
        tick();
        areset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(5'b00000, 1'b0, 1'b0, 1'b1);
            tick();
        end

        run_cmd(4'h6, 2, 0, 1'b0, 1'b0, 4'h0);
        run_cmd(4'hC, 2, 2, 1'b0, 1'b0, 4'h0);
        run_cmd(4'h1, 1, 1, 1'b0, 1'b0, 4'h0);

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_left observed=%0d expected=0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
